// File: rtl/goomba_sprite_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : goomba_pkg
//  Description : Shared types, widths and default sprite constants for the
//                Goomba sprite controller and its address generator.
//  Contents    : goomba_state_t life-cycle encoding, COORD_W/ADDR_W/COLOR_W,
//                default sprite size and transparent palette key.
//  Revision    : 1.0 - initial release
// ============================================================================
package goomba_pkg;

  typedef enum logic [1:0] {
    DEAD     = 2'd0,
    WALK     = 2'd1,
    SQUISHED = 2'd2
  } goomba_state_t;

  localparam int COORD_W = 10;
  localparam int ADDR_W  = 9;
  localparam int COLOR_W = 12;

  localparam int DEF_SPRITE_W = 21;
  localparam int DEF_SPRITE_H = 21;
  localparam logic [COLOR_W-1:0] DEF_TRANSPARENT_KEY = 12'h808;

endpackage
`default_nettype wire

// File: rtl/goomba_sprite_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : goomba_sprite_ctrl_if
//  Description : Signal bundle between the game logic / VGA controller /
//                palette ROMs and the Goomba sprite controller.
//  Ports       : frame_tick, spawn, stomp      - game events
//                goomba_x/y, draw_x/y          - sprite origin, VGA pixel
//                rom_addr, walk0/1, squish     - shared ROM address and data
//                pixel_color, pixel_opaque     - colour-mapper output
//                state, alive                  - life-cycle status
//  Modports    : slave  - the sprite controller
//                master - the surrounding system
//  Revision    : 1.0 - initial release
// ============================================================================
interface goomba_sprite_ctrl_if
  import goomba_pkg::*;
();

  logic                frame_tick;
  logic                spawn;
  logic                stomp;
  logic [COORD_W-1:0]  goomba_x;
  logic [COORD_W-1:0]  goomba_y;
  logic [COORD_W-1:0]  draw_x;
  logic [COORD_W-1:0]  draw_y;
  logic [ADDR_W-1:0]   rom_addr;
  logic [COLOR_W-1:0]  walk0_color;
  logic [COLOR_W-1:0]  walk1_color;
  logic [COLOR_W-1:0]  squish_color;
  logic [COLOR_W-1:0]  pixel_color;
  logic                pixel_opaque;
  goomba_state_t       state;
  logic                alive;

  modport slave (
    input  frame_tick, spawn, stomp,
    input  goomba_x, goomba_y, draw_x, draw_y,
    input  walk0_color, walk1_color, squish_color,
    output rom_addr, pixel_color, pixel_opaque, state, alive
  );

  modport master (
    output frame_tick, spawn, stomp,
    output goomba_x, goomba_y, draw_x, draw_y,
    output walk0_color, walk1_color, squish_color,
    input  rom_addr, pixel_color, pixel_opaque, state, alive
  );

endinterface
`default_nettype wire

// File: rtl/goomba_sprite_ctrl_sprite_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_addr_gen
//  Description : Registered sprite bounding-box test and row-major ROM
//                address generation for one sprite.
//  Ports       : Clk, Reset_n      - clock, async active-low reset
//                draw_x, draw_y    - current VGA pixel
//                obj_x, obj_y      - sprite top-left corner
//                rom_addr          - dy*SPRITE_W+dx inside the box, else 0
//                in_box            - pixel lies inside the sprite box
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_addr_gen
  import goomba_pkg::*;
#(
  parameter int SPRITE_W = DEF_SPRITE_W,
  parameter int SPRITE_H = DEF_SPRITE_H
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [COORD_W-1:0]  draw_x,
  input  logic [COORD_W-1:0]  draw_y,
  input  logic [COORD_W-1:0]  obj_x,
  input  logic [COORD_W-1:0]  obj_y,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                in_box
);

  localparam logic [COORD_W-1:0] c_sprite_w = COORD_W'(SPRITE_W);
  localparam logic [COORD_W-1:0] c_sprite_h = COORD_W'(SPRITE_H);

  // Unsigned wrap-around subtraction: a pixel left of / above the sprite
  // yields a large offset and falls out of the box on its own.
  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;
  logic               w_in_box;
  logic [ADDR_W-1:0]  w_addr;

  assign w_dx     = draw_x - obj_x;
  assign w_dy     = draw_y - obj_y;
  assign w_in_box = (w_dx < c_sprite_w) && (w_dy < c_sprite_h);

  // Computed modulo 2^ADDR_W; the sprite area fits the ROM depth.
  assign w_addr = ADDR_W'(w_dy) * ADDR_W'(SPRITE_W) + ADDR_W'(w_dx);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      in_box   <= 1'b0;
    end else begin
      rom_addr <= w_in_box ? w_addr : '0;
      in_box   <= w_in_box;
    end
  end

endmodule
`default_nettype wire

// File: rtl/goomba_sprite_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : goomba_sprite_ctrl
//  Description : Goomba life-cycle sequencer (dead / walk / squished) with a
//                two-stage pixel pipeline feeding the colour mapper.
//  Ports       : Clk, Reset_n  - clock, async active-low reset
//                bus (slave)   - events, coordinates, ROM address/data,
//                                pixel colour/opaque, state, alive
//  Revision    : 1.0 - initial release
// ============================================================================
module goomba_sprite_ctrl
  import goomba_pkg::*;
#(
  parameter int                  SPRITE_W        = DEF_SPRITE_W,
  parameter int                  SPRITE_H        = DEF_SPRITE_H,
  parameter int                  ANIM_FRAMES     = 8,
  parameter int                  SQUISH_FRAMES   = 30,
  parameter logic [COLOR_W-1:0]  TRANSPARENT_KEY = DEF_TRANSPARENT_KEY
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  goomba_sprite_ctrl_if.slave    bus
);

  localparam int c_anim_w   = (ANIM_FRAMES   > 1) ? $clog2(ANIM_FRAMES)   : 1;
  localparam int c_squish_w = (SQUISH_FRAMES > 1) ? $clog2(SQUISH_FRAMES) : 1;
  localparam logic [c_anim_w-1:0]   c_anim_last   = c_anim_w'(ANIM_FRAMES - 1);
  localparam logic [c_squish_w-1:0] c_squish_last = c_squish_w'(SQUISH_FRAMES - 1);

  // --------------------------------------------------------------------------
  // Life-cycle FSM
  // --------------------------------------------------------------------------
  goomba_state_t          r_state,      w_state_nx;
  logic [c_anim_w-1:0]    r_anim_cnt,   w_anim_nx;
  logic                   r_walk_frame, w_frame_nx;
  logic [c_squish_w-1:0]  r_squish_cnt, w_squish_nx;
  logic                   r_alive;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= DEAD;
      r_anim_cnt   <= '0;
      r_walk_frame <= 1'b0;
      r_squish_cnt <= '0;
      r_alive      <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_anim_cnt   <= w_anim_nx;
      r_walk_frame <= w_frame_nx;
      r_squish_cnt <= w_squish_nx;
      r_alive      <= (w_state_nx == WALK);
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_anim_nx   = r_anim_cnt;
    w_frame_nx  = r_walk_frame;
    w_squish_nx = r_squish_cnt;

    // spawn overrides everything, including a simultaneous stomp
    if (bus.spawn) begin
      w_state_nx  = WALK;
      w_anim_nx   = '0;
      w_frame_nx  = 1'b0;
      w_squish_nx = '0;
    end else begin
      case (r_state)
        DEAD: begin
        end
        WALK: begin
          if (bus.stomp) begin
            w_state_nx  = SQUISHED;
            w_squish_nx = '0;
          end else if (bus.frame_tick) begin
            if (r_anim_cnt == c_anim_last) begin
              w_anim_nx  = '0;
              w_frame_nx = ~r_walk_frame;
            end else begin
              w_anim_nx = r_anim_cnt + c_anim_w'(1);
            end
          end
        end
        SQUISHED: begin
          if (bus.frame_tick) begin
            if (r_squish_cnt == c_squish_last) begin
              w_state_nx  = DEAD;
              w_squish_nx = '0;
            end else begin
              w_squish_nx = r_squish_cnt + c_squish_w'(1);
            end
          end
        end
        default: begin
          w_state_nx = DEAD;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Pixel stage 1: box test / ROM address plus a state snapshot so that the
  // colour selected in stage 2 belongs to the same pixel as the address.
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_rom_addr;
  logic              w_s1_in_box;
  goomba_state_t     r_s1_state;
  logic              r_s1_frame;

  sprite_addr_gen #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_addr_gen (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .draw_x   (bus.draw_x),
    .draw_y   (bus.draw_y),
    .obj_x    (bus.goomba_x),
    .obj_y    (bus.goomba_y),
    .rom_addr (w_rom_addr),
    .in_box   (w_s1_in_box)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_state <= DEAD;
      r_s1_frame <= 1'b0;
    end else begin
      r_s1_state <= r_state;
      r_s1_frame <= r_walk_frame;
    end
  end

  // --------------------------------------------------------------------------
  // Pixel stage 2: sample the combinational ROMs and key out transparency
  // --------------------------------------------------------------------------
  logic [COLOR_W-1:0] w_sel_color;
  logic               w_opaque;
  logic [COLOR_W-1:0] r_pix_color;
  logic               r_pix_opaque;

  assign w_sel_color = (r_s1_state == SQUISHED) ? bus.squish_color :
                       (r_s1_frame ? bus.walk1_color : bus.walk0_color);
  assign w_opaque    = w_s1_in_box && (r_s1_state != DEAD) &&
                       (w_sel_color != TRANSPARENT_KEY);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pix_color  <= '0;
      r_pix_opaque <= 1'b0;
    end else begin
      r_pix_color  <= w_opaque ? w_sel_color : '0;
      r_pix_opaque <= w_opaque;
    end
  end

  assign bus.rom_addr     = w_rom_addr;
  assign bus.pixel_color  = r_pix_color;
  assign bus.pixel_opaque = r_pix_opaque;
  assign bus.state        = r_state;
  assign bus.alive        = r_alive;

endmodule
`default_nettype wire

// File: tb/tb_goomba_sprite_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_goomba_sprite_ctrl
//  Description : Self-checking bench for goomba_sprite_ctrl. A tick-count
//                model predicts state, alive, ROM address and pixel output
//                every cycle; directed steps add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_goomba_sprite_ctrl;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  goomba_sprite_ctrl_if ifc ();

  goomba_sprite_ctrl dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (ifc)
  );

  // Combinational ROM images
  logic [11:0] rom0 [512];
  logic [11:0] rom1 [512];
  logic [11:0] rsq  [512];

  assign ifc.walk0_color  = rom0[ifc.rom_addr];
  assign ifc.walk1_color  = rom1[ifc.rom_addr];
  assign ifc.squish_color = rsq[ifc.rom_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: life cycle from tick counts; walk frame = (walk ticks / 8) mod 2,
  // despawn on the 30th squish tick. Pixels from plain box arithmetic.
  // --------------------------------------------------------------------------
  int m_state, m_ticks, m_sq;
  int s1_in, s1_state, s1_frame;
  int e_addr, e_col, e_op, e_state, e_alive;
  int m_sel, m_dx, m_dy;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_state = 0; m_ticks = 0; m_sq = 0;
      s1_in = 0; s1_state = 0; s1_frame = 0;
      e_addr = 0; e_col = 0; e_op = 0; e_state = 0; e_alive = 0;
    end else begin
      // stage 2 uses the previous pixel's snapshot and address
      m_sel = (s1_state == 2) ? int'(rsq[e_addr]) :
              (s1_frame != 0 ? int'(rom1[e_addr]) : int'(rom0[e_addr]));
      e_op  = (s1_in != 0 && s1_state != 0 && m_sel != 'h808) ? 1 : 0;
      e_col = (e_op != 0) ? m_sel : 0;
      // stage 1 for the pixel presented now
      m_dx   = (int'(ifc.draw_x) - int'(ifc.goomba_x)) & 1023;
      m_dy   = (int'(ifc.draw_y) - int'(ifc.goomba_y)) & 1023;
      s1_in  = (m_dx < 21 && m_dy < 21) ? 1 : 0;
      e_addr = (s1_in != 0) ? ((m_dy * 21 + m_dx) % 512) : 0;
      s1_state = m_state;
      s1_frame = (m_ticks / 8) % 2;
      // life cycle
      if (ifc.spawn) begin
        m_state = 1; m_ticks = 0; m_sq = 0;
      end else if (m_state == 1 && ifc.stomp) begin
        m_state = 2; m_sq = 0;
      end else if (ifc.frame_tick) begin
        if (m_state == 1) m_ticks++;
        else if (m_state == 2) begin
          m_sq++;
          if (m_sq == 30) m_state = 0;
        end
      end
      e_state = m_state;
      e_alive = (m_state == 1) ? 1 : 0;
    end
  end

  always @(negedge Clk) begin
    chk("state",        int'(ifc.state),       e_state);
    chk("alive",        int'(ifc.alive),       e_alive);
    chk("rom_addr",     int'(ifc.rom_addr),    e_addr);
    chk("pixel_color",  int'(ifc.pixel_color), e_col);
    chk("pixel_opaque", int'(ifc.pixel_opaque), e_op);
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_tick();
    ifc.frame_tick = 1'b1;
    step();
    ifc.frame_tick = 1'b0;
    step();
    step();
  endtask

  initial begin
    ifc.frame_tick = 1'b0;
    ifc.spawn      = 1'b0;
    ifc.stomp      = 1'b0;
    ifc.goomba_x   = 10'd100;
    ifc.goomba_y   = 10'd200;
    ifc.draw_x     = 10'd0;
    ifc.draw_y     = 10'd0;
    for (int i = 0; i < 512; i++) begin
      rom0[i] = 12'hA00 ^ 12'(i);
      rom1[i] = 12'h500 ^ 12'(i);
      rsq[i]  = 12'h300 ^ 12'(i);
    end

    // Reset and idle
    repeat (3) step();
    chk("reset_state", int'(ifc.state), 0);
    chk("reset_pixel_color", int'(ifc.pixel_color), 0);
    Reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ifc.draw_x = 10'((i * 7) % 640);
      ifc.draw_y = 10'(150 + i);
      step();
      if (i == 99) chk("idle_opaque", int'(ifc.pixel_opaque), 0);
    end
    chk("idle_alive", int'(ifc.alive), 0);

    // Spawn and address corners
    rom0[0]   = 12'h222;
    rom0[440] = 12'h808;
    ifc.spawn = 1'b1;
    step();
    ifc.spawn = 1'b0;
    chk("spawn_state", int'(ifc.state), 1);
    ifc.draw_x = 10'd100; ifc.draw_y = 10'd200;
    step();
    chk("addr_topleft", int'(ifc.rom_addr), 0);
    ifc.draw_x = 10'd120; ifc.draw_y = 10'd220;
    step();
    chk("addr_botright", int'(ifc.rom_addr), 440);
    chk("opaque_222", int'(ifc.pixel_opaque), 1);
    chk("color_222", int'(ifc.pixel_color), 'h222);
    ifc.draw_x = 10'd99; ifc.draw_y = 10'd200;
    step();
    chk("opaque_key", int'(ifc.pixel_opaque), 0);
    chk("color_key", int'(ifc.pixel_color), 0);
    chk("addr_left_out", int'(ifc.rom_addr), 0);
    ifc.draw_x = 10'd121;
    step();
    chk("addr_right_out", int'(ifc.rom_addr), 0);
    ifc.goomba_x = 10'd1015; ifc.draw_x = 10'd5; ifc.draw_y = 10'd201;
    step();
    chk("addr_wrap", int'(ifc.rom_addr), 35);
    ifc.goomba_x = 10'd100;

    // Walk animation
    for (int i = 0; i < 512; i++) begin
      rom0[i] = 12'hE51;
      rom1[i] = 12'hFDB;
    end
    ifc.draw_x = 10'd110; ifc.draw_y = 10'd210;
    for (int k = 1; k <= 8; k++) begin
      do_tick();
      chk("walk_color", int'(ifc.pixel_color), (k < 8) ? 'hE51 : 'hFDB);
    end

    // Stomp and squish countdown
    ifc.stomp = 1'b1;
    step();
    ifc.stomp = 1'b0;
    chk("stomp_state", int'(ifc.state), 2);
    chk("stomp_alive", int'(ifc.alive), 0);
    for (int k = 1; k <= 30; k++) begin
      ifc.frame_tick = 1'b1;
      step();
      ifc.frame_tick = 1'b0;
      step();
      chk("squish_state", int'(ifc.state), (k < 30) ? 2 : 0);
      if (k == 5) chk("squish_color", int'(ifc.pixel_color), 'h3DC);
    end

    // spawn + stomp together, then counters restart
    ifc.spawn = 1'b1;
    step();
    ifc.spawn = 1'b0;
    repeat (3) do_tick();
    ifc.spawn = 1'b1; ifc.stomp = 1'b1;
    step();
    ifc.spawn = 1'b0; ifc.stomp = 1'b0;
    chk("spawn_wins_state", int'(ifc.state), 1);
    chk("spawn_wins_alive", int'(ifc.alive), 1);
    for (int k = 1; k <= 8; k++) begin
      do_tick();
      chk("rewalk_color", int'(ifc.pixel_color), (k < 8) ? 'hE51 : 'hFDB);
    end

    // stomp while DEAD is ignored
    ifc.stomp = 1'b1;
    step();
    ifc.stomp = 1'b0;
    repeat (30) do_tick();
    chk("despawned", int'(ifc.state), 0);
    ifc.stomp = 1'b1;
    step();
    ifc.stomp = 1'b0;
    chk("dead_stomp_state", int'(ifc.state), 0);
    chk("dead_stomp_alive", int'(ifc.alive), 0);

    // Asynchronous reset in the middle of SQUISHED
    ifc.spawn = 1'b1;
    step();
    ifc.spawn = 1'b0;
    ifc.stomp = 1'b1;
    step();
    ifc.stomp = 1'b0;
    repeat (3) do_tick();
    chk("pre_reset_opaque", int'(ifc.pixel_opaque), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_state", int'(ifc.state), 0);
    chk("async_alive", int'(ifc.alive), 0);
    chk("async_rom_addr", int'(ifc.rom_addr), 0);
    chk("async_color", int'(ifc.pixel_color), 0);
    chk("async_opaque", int'(ifc.pixel_opaque), 0);
    step();
    step();
    Reset_n = 1'b1;
    repeat (5) step();
    chk("post_reset_state", int'(ifc.state), 0);
    ifc.spawn = 1'b1;
    step();
    ifc.spawn = 1'b0;
    chk("respawn_state", int'(ifc.state), 1);
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
